// File: rtl/mux_pkg.sv
// Shared definitions for the registered stream multiplexer: mode encodings,
// output-stage state type and small elaboration/arithmetic helpers.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Ceiling log2, never below 1 so a field always has at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return (w == 0) ? 1 : w;
  endfunction

  // Next round-robin start position after channel ptr was served.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr,
// wrapping to channel 0. The pointer register lives in the parent.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              any_grant
);

  // Two ordered passes: channels from rr_ptr upward, then the wrapped low part.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_grant && req[c] && (c >= int'(rr_ptr))) begin
        any_grant = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (!any_grant && req[c] && (c < int'(rr_ptr))) begin
        any_grant = 1'b1;
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select or round-robin
// arbitration and a single-entry valid/ready output stage.
// Optional packet lock (hold the grant until in_last) is built when the
// macro MUX_LOCK_EN is defined; otherwise in_last is ignored.
//
// Output stage states:
//   state     | meaning
//   OUT_EMPTY | output register holds no word, any grant may load
//   OUT_FULL  | output register holds a word for the consumer
module stream_mux_rr
  import mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  out_state_e          state_q, state_d;
  logic [SEL_W-1:0]    rr_ptr_q;
  logic [NUM_CH-1:0]   arb_grant;
  logic [SEL_W-1:0]    arb_idx;
  logic                arb_any;
  logic [SEL_W-1:0]    cand;
  logic [NUM_CH-1:0]   grant_vec;
  logic                grant_valid;
  logic [DATA_W-1:0]   cand_data;
  logic                cand_last;
  logic                load;
  logic                xfer;
  logic                locked;
  logic [SEL_W-1:0]    locked_ch;
  logic                ptr_adv;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(SEL_W)) u_arb (
    .req       (in_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  assign out_valid = (state_q == OUT_FULL);
  assign load      = !out_valid || out_ready;
  assign xfer      = rst_n && load && grant_valid;
  assign in_ready  = xfer ? grant_vec : '0;

  // Pick the candidate channel; an out-of-range sel matches no channel.
  always_comb begin
    cand        = sel;
    grant_vec   = '0;
    grant_valid = 1'b0;
    cand_data   = '0;
    cand_last   = 1'b0;
    if (locked) begin
      cand = locked_ch;
    end else if (mode == MODE_RR) begin
      cand = arb_idx;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(cand) == c) begin
        grant_vec[c] = 1'b1;
        grant_valid  = in_valid[c];
        cand_data    = in_data[c*DATA_W +: DATA_W];
        cand_last    = in_last[c];
      end
    end
    if (!locked && (mode == MODE_RR)) begin
      grant_vec   = arb_grant;
      grant_valid = arb_any;
    end
  end

`ifdef MUX_LOCK_EN
  logic             lock_q;
  logic [SEL_W-1:0] locked_ch_q;

  assign locked    = lock_q;
  assign locked_ch = locked_ch_q;
  assign ptr_adv   = cand_last;

  // A word without in_last opens (or keeps) a packet on its channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q      <= 1'b0;
      locked_ch_q <= '0;
    end else if (xfer) begin
      lock_q      <= !cand_last;
      locked_ch_q <= cand;
    end
  end
`else
  logic unused_last;

  assign locked      = 1'b0;
  assign locked_ch   = '0;
  assign ptr_adv     = 1'b1;
  assign unused_last = cand_last;
`endif

  // Round-robin pointer moves past the served channel only in RR mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (xfer && (mode == MODE_RR) && ptr_adv) begin
      rr_ptr_q <= SEL_W'(rr_next(int'(cand), NUM_CH));
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OUT_EMPTY;
    else        state_q <= state_d;
  end

  // Output stage next state: load wins over drain, so no bubble on drain+load.
  always_comb begin
    state_d = state_q;
    if (xfer)           state_d = OUT_FULL;
    else if (out_ready) state_d = OUT_EMPTY;
  end

  // Output data/channel capture; held when draining without a new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= '0;
    end else if (xfer) begin
      out_data <= cand_data;
      out_ch   <= cand;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with a cycle-level reference model.
module tb_stream_mux_rr;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     mode = 1'b0;
  logic [SEL_W-1:0]         sel = '0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH-1:0]        in_last = 4'hF;
  logic [NUM_CH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  stream_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the output register must hold.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_ptr;
  bit       m_lock;
  int       m_lch;

  // Channel the rules allow this cycle, or -1.
  function automatic int pick();
    if (m_lock) return in_valid[m_lch] ? m_lch : -1;
    if (mode == 1'b0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_ptr + k) % NUM_CH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit m_load();
    return !m_valid || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int g;
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_lock = 0; m_lch = 0;
    end else begin
      g = pick();
      if (m_load() && g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*DATA_W +: DATA_W];
        m_ch    = g;
`ifdef MUX_LOCK_EN
        if (mode && in_last[g]) m_ptr = (g + 1) % NUM_CH;
        m_lock = !in_last[g];
        m_lch  = g;
`else
        if (mode) m_ptr = (g + 1) % NUM_CH;
`endif
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  always begin : compare
    int g;
    logic [3:0] er;
    @(negedge clk);
    #2;
    g  = pick();
    er = (rst_n && m_load() && g >= 0) ? 4'(1 << g) : 4'h0;
    chk("cyc_in_ready", 32'(in_ready), 32'(er));
    chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_out_data", 32'(out_data), 32'(m_data));
    chk("cyc_out_ch", 32'(out_ch), 32'(m_ch));
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  int       f_sel[4]  = '{2, 0, 1, 3};
  bit [7:0] f_dat[4]  = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
  bit [3:0] s_vld[4]  = '{4'b0100, 4'b0010, 4'b1111, 4'b0001};
  int       s_exp[4]  = '{2, 1, 2, 0};
`ifdef MUX_LOCK_EN
  int       l_exp[4]  = '{1, 1, 1, 2};
`else
  int       l_exp[4]  = '{1, 2, 1, 2};
`endif

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // fixed select
    mode = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = SEL_W'(f_sel[i]);
      in_valid = 4'(1 << f_sel[i]);
      in_data = '0;
      in_data[f_sel[i]*DATA_W +: DATA_W] = f_dat[i];
      step();
      chk("fixed_data", 32'(out_data), 32'(f_dat[i]));
      chk("fixed_ch", 32'(out_ch), 32'(f_sel[i]));
    end

    // round-robin fairness, no bubbles
    mode = 1'b1;
    in_valid = 4'hF;
    in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_fair_ch", 32'(out_ch), 32'(k % 4));
      chk("rr_fair_valid", 32'(out_valid), 32'h1);
    end

    // sparse requests with wrap
    for (int i = 0; i < 4; i++) begin
      in_valid = s_vld[i];
      step();
      chk("rr_sparse_ch", 32'(out_ch), 32'(s_exp[i]));
    end

    // backpressure: held word ch0 / 8'h10
    out_ready = 1'b0;
    in_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_data", 32'(out_data), 32'h10);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'h2);
    step();
    chk("bp_release_ch", 32'(out_ch), 32'h1);
    chk("bp_release_data", 32'(out_data), 32'h11);

    // packet lock scenario
    in_valid = 4'b0001;
    step();
    chk("lock_pre_ch", 32'(out_ch), 32'h0);
    in_valid = 4'b0110;
    for (int k = 0; k < 4; k++) begin
      in_last = 4'b1101;
      in_last[1] = (k == 2);
      in_data[15:8] = 8'(8'h21 + k);
      step();
      chk("lock_seq_ch", 32'(out_ch), 32'(l_exp[k]));
    end
    in_last = 4'hF;

    // reset while a word is held
    out_ready = 1'b0;
    in_valid = 4'hF;
    step();
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", 32'(out_data), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    mode = 1'b1;
    step();
    chk("post_rst_ch", 32'(out_ch), 32'h0);
    chk("post_rst_data", 32'(out_data), 32'h10);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
